// File: rtl/mul_arb_pkg.sv
// Shared constants and types for the 4-channel multiplier arbiter.
package mul_arb_pkg;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned OPND_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } opnd_t;

  function automatic logic [NREQ-1:0] tag_onehot(tag_t t);
    tag_onehot    = '0;
    tag_onehot[t] = 1'b1;
  endfunction
endpackage

// File: rtl/mul_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per product in flight.
module mul_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/mul_arbiter_4ch.sv
// Round-robin arbiter sharing one in-order pipelined multiplier among 4
// requesters; a tag FIFO routes each product back to its issuer.
module mul_arbiter_4ch #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req_valid,
  input  logic [NREQ*mul_arb_pkg::OPND_W-1:0]   req_a,
  input  logic [NREQ*mul_arb_pkg::OPND_W-1:0]   req_b,
  output logic [NREQ-1:0]                       req_ready,
  output logic [mul_arb_pkg::OPND_W-1:0]        mul_a,
  output logic [mul_arb_pkg::OPND_W-1:0]        mul_b,
  output logic                                  mul_en_in,
  input  logic                                  mul_en_out,
  input  logic [mul_arb_pkg::PROD_W-1:0]        mul_out,
  output logic [NREQ-1:0]                       resp_valid,
  output logic [mul_arb_pkg::PROD_W-1:0]        resp_data,
  output logic                                  busy,
  output logic                                  err_orphan
);
  import mul_arb_pkg::*;

  tag_t                      ptr_q, ptr_d, gnt_idx, cand, head;
  logic                      gnt_vld, pop;
  opnd_t                     issue_q, issue_d;
  logic                      mul_en_q;
  logic [NREQ-1:0]           resp_valid_q, resp_valid_d;
  logic [PROD_W-1:0]         resp_data_q, resp_data_d;
  logic                      err_q, err_d;
  logic [$clog2(TAG_DEPTH):0] tag_cnt;
  logic                      fifo_full, fifo_empty;

  // Grant uses the pre-update tag count, so mul_en_out never reaches req_ready.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + tag_t'(k);
      if (!gnt_vld && req_valid[cand] && !fifo_full && !rst) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    ptr_d   = gnt_vld ? gnt_idx + tag_t'(1) : ptr_q;
    issue_d = '0;
    if (gnt_vld) begin
      issue_d.a = req_a[gnt_idx*OPND_W +: OPND_W];
      issue_d.b = req_b[gnt_idx*OPND_W +: OPND_W];
    end
    pop          = mul_en_out & ~fifo_empty;
    resp_valid_d = pop ? tag_onehot(head) : '0;
    resp_data_d  = pop ? mul_out : '0;
    err_d        = mul_en_out & fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      issue_q      <= '0;
      mul_en_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      issue_q      <= issue_d;
      mul_en_q     <= gnt_vld;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  mul_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TAG_W)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push_i  (gnt_vld),
    .pop_i   (pop),
    .din_i   (gnt_idx),
    .head_o  (head),
    .count_o (tag_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mul_a      = issue_q.a;
  assign mul_b      = issue_q.b;
  assign mul_en_in  = mul_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err_orphan = err_q;
  assign busy       = (tag_cnt != '0);
endmodule

// File: tb/tb_mul_arbiter_4ch.sv
// Bench for mul_arbiter_4ch: 4-cycle in-order multiplier stub, queue-based
// reference model, table-driven single requests and directed corner cases.
module tb_mul_arbiter_4ch;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [7:0]  mul_a, mul_b;
  logic        mul_en_in, mul_en_out;
  logic [15:0] mul_out;
  logic [3:0]  resp_valid;
  logic [15:0] resp_data;
  logic        busy, err_orphan;

  always #5 clk = ~clk;

  mul_arbiter_4ch #(.NREQ(4), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_en_in(mul_en_in),
    .mul_en_out(mul_en_out), .mul_out(mul_out), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy), .err_orphan(err_orphan)
  );

  // multiplier stub: fixed 4-cycle product pipe, overridable by hand
  logic [3:0]  pv = '0;
  logic [15:0] pp [4];
  logic        stub_en, man_en;
  logic [15:0] man_out;
  always @(posedge clk) begin
    pv    <= {pv[2:0], mul_en_in === 1'b1};
    pp[0] <= {8'd0, mul_a} * {8'd0, mul_b};
    pp[1] <= pp[0];
    pp[2] <= pp[1];
    pp[3] <= pp[2];
  end
  assign mul_en_out = stub_en ? pv[3] : man_en;
  assign mul_out    = stub_en ? pp[3] : man_out;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // reference model: round-robin pointer, queue of outstanding tags
  logic        model_on = 1'b0;
  int          m_ptr = 0;
  int          m_tags[$];
  logic        m_en = 1'b0, m_err = 1'b0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [3:0]  m_rv = '0, m_er;
  logic [15:0] m_rd = '0;
  int          m_g, m_c, m_t;

  always @(negedge clk) if (model_on) begin
    m_er = '0;
    m_g  = -1;
    if (!rst && m_tags.size() < 8)
      for (int k = 0; k < 4; k++) begin
        m_c = (m_ptr + k) % 4;
        if (m_g < 0 && req_valid[m_c]) m_g = m_c;
      end
    if (m_g >= 0) m_er[m_g] = 1'b1;
    chk("m_ready", req_ready, m_er);
    chk("m_en_in", mul_en_in, m_en);
    chk("m_mul_a", mul_a, m_a);
    chk("m_mul_b", mul_b, m_b);
    chk("m_resp_valid", resp_valid, m_rv);
    chk("m_resp_data", resp_data, m_rd);
    chk("m_busy", busy, m_tags.size() != 0);
    chk("m_orphan", err_orphan, m_err);
    if (rst) begin
      m_ptr = 0; m_tags.delete();
      m_en = 0; m_a = 0; m_b = 0; m_rv = 0; m_rd = 0; m_err = 0;
    end else begin
      m_en = (m_g >= 0);
      m_a  = (m_g >= 0) ? req_a[8*m_g +: 8] : 8'd0;
      m_b  = (m_g >= 0) ? req_b[8*m_g +: 8] : 8'd0;
      m_rv = 0; m_rd = 0; m_err = 0;
      if (mul_en_out) begin
        if (m_tags.size() > 0) begin
          m_t = m_tags.pop_front();
          m_rv[m_t] = 1'b1;
          m_rd = mul_out;
        end else m_err = 1'b1;
      end
      if (m_g >= 0) begin
        m_tags.push_back(m_g);
        m_ptr = (m_g + 1) % 4;
      end
    end
  end

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] exp_oh;
    logic [15:0] exp_p;
  } vec_t;
  vec_t tbl [6];
  vec_t v;
  int   cnt, cnt2;

  initial begin
    tbl[0] = '{2, 8'd3,   8'd5,   4'b0100, 16'd15};
    tbl[1] = '{3, 8'd255, 8'd255, 4'b1000, 16'd65025};
    tbl[2] = '{0, 8'd0,   8'd77,  4'b0001, 16'd0};
    tbl[3] = '{1, 8'd16,  8'd16,  4'b0010, 16'd256};
    tbl[4] = '{0, 8'd128, 8'd2,   4'b0001, 16'd256};
    tbl[5] = '{1, 8'd1,   8'd255, 4'b0010, 16'd255};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    stub_en = 1'b1; man_en = 1'b0; man_out = '0;
    nxt();
    model_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_en_in", mul_en_in, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_orphan", err_orphan, 0);
    nxt();
    rst = 1'b0;

    // isolated single requests: issue at H+1, response at H+6
    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      req_valid = 4'(1 << v.req);
      req_a = 32'(v.a) << (8*v.req);
      req_b = 32'(v.b) << (8*v.req);
      @(negedge clk);
      chk("tbl_ready", req_ready, v.exp_oh);
      nxt();
      req_valid = '0; req_a = '0; req_b = '0;
      @(negedge clk);
      chk("tbl_en_in", mul_en_in, 1);
      chk("tbl_mul_a", mul_a, v.a);
      chk("tbl_mul_b", mul_b, v.b);
      for (int c = 0; c < 4; c++) begin
        nxt();
        @(negedge clk);
        chk("tbl_early_resp", resp_valid, 0);
        chk("tbl_busy", busy, 1);
      end
      nxt();
      @(negedge clk);
      chk("tbl_resp_valid", resp_valid, v.exp_oh);
      chk("tbl_resp_data", resp_data, v.exp_p);
      chk("tbl_busy_end", busy, 0);
      nxt();
    end

    // saturation from ptr=0
    rst = 1'b1; nxt(); rst = 1'b0;
    req_valid = 4'hF;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd13, 8'd12, 8'd11, 8'd10};
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k < 16) chk("sat_grant", req_ready, 32'(1 << (k % 4)));
      if (k >= 1 && k <= 16) chk("sat_en_in", mul_en_in, 1);
      if (k >= 6 && k <= 21) begin
        chk("sat_resp_valid", resp_valid, 32'(1 << ((k-6) % 4)));
        chk("sat_resp_data", resp_data, 32'((((k-6) % 4) + 1) * (10 + ((k-6) % 4))));
      end
      nxt();
      if (k == 15) req_valid = '0;
    end

    // full FIFO: multiplier withholds results
    stub_en = 1'b0;
    req_valid = 4'hF;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready != 0) cnt++;
      nxt();
    end
    chk("full_grants", cnt, 8);
    chk("full_busy", busy, 1);
    man_en = 1'b1; man_out = 16'hBEEF;
    @(negedge clk);
    chk("full_pop_ready", req_ready, 0);
    nxt();
    man_en = 1'b0;
    cnt2 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("full_resp_valid", resp_valid, 4'b0001);
        chk("full_resp_data", resp_data, 16'hBEEF);
      end
      if (req_ready != 0) cnt2++;
      nxt();
    end
    chk("full_one_more", cnt2, 1);
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      man_en = 1'b1; man_out = 16'(k + 100);
      nxt();
    end
    man_en = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("full_drained", busy, 0);
    nxt();

    // orphan result
    man_en = 1'b1; man_out = 16'h1234;
    nxt();
    man_en = 1'b0;
    @(negedge clk);
    chk("orph_pulse", err_orphan, 1);
    chk("orph_resp", resp_valid, 0);
    nxt();
    @(negedge clk);
    chk("orph_clear", err_orphan, 0);
    chk("orph_busy", busy, 0);
    nxt();
    stub_en = 1'b1;

    // reset with 3 tags in flight (multiplier stub is not reset)
    req_valid = 4'hF;
    req_a = 32'h0A0B0C0D; req_b = 32'h01020304;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstf_grant", req_ready, 32'(1 << ((1 + k) % 4)));
      nxt();
    end
    req_valid = '0; rst = 1'b1;
    nxt();
    rst = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) chk("rstf_busy", busy, 0);
      if (err_orphan === 1'b1) cnt++;
      if (resp_valid !== 4'b0000) cnt2++;
      nxt();
    end
    chk("rstf_orphans", cnt, 3);
    chk("rstf_no_resp", cnt2, 0);
    req_valid = 4'hF;
    @(negedge clk);
    chk("rstf_ptr0", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    repeat (8) nxt();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a = $urandom;
      req_b = $urandom;
      nxt();
    end
    req_valid = '0;
    repeat (10) nxt();
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
